// File: rtl/win_pkg.sv
// Shared types, 7-segment codes and direction step table for the win scanner.
package win_pkg;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_GRN  = 2'd1,
        RES_RED  = 2'd2,
        RES_DRAW = 2'd3
    } result_e;

    typedef enum logic [1:0] {
        DIR_HORZ = 2'd0,
        DIR_VERT = 2'd1,
        DIR_DIAG = 2'd2,
        DIR_ANTI = 2'd3
    } dir_e;

    localparam logic [6:0] SEG_GRN   = 7'b1111001;
    localparam logic [6:0] SEG_RED   = 7'b0100100;
    localparam logic [6:0] SEG_DRAW  = 7'b0100001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Indexed by dir_e: horizontal, vertical, diagonal, anti-diagonal.
    localparam logic signed [1:0] ROW_STEP [4] = '{2'sd0, 2'sd1, 2'sd1,  2'sd1};
    localparam logic signed [1:0] COL_STEP [4] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};

    function automatic logic [6:0] seg_of(input result_e res);
        case (res)
            RES_GRN:  return SEG_GRN;
            RES_RED:  return SEG_RED;
            RES_DRAW: return SEG_DRAW;
            default:  return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/win_run_count.sv
// Combinational run length through one cell along a step direction, both ways,
// saturated at WIN_LEN; cells beyond the board edge end the run.
module win_run_count
    import win_pkg::*;
#(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int WIN_LEN = 4
) (
    input  logic [ROWS-1:0][COLS-1:0]    board,
    input  logic [4:0]                   row,
    input  logic [4:0]                   col,
    input  logic signed [1:0]            drow,
    input  logic signed [1:0]            dcol,
    output logic [$clog2(WIN_LEN+1)-1:0] run
);

    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);
    localparam int RUNW = $clog2(WIN_LEN+1);

    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    function automatic logic cell_at(input board_t b, input int r, input int c);
        logic [RW-1:0] ri;
        logic [CW-1:0] ci;
        cell_at = 1'b0;
        if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
            ri = RW'(r);
            ci = CW'(c);
            cell_at = b[ri][ci];
        end
    endfunction

    function automatic int side_run(input board_t b, input int r0, input int c0,
                                    input int dr, input int dc);
        int  n;
        logic alive;
        n = 0;
        alive = 1'b1;
        for (int k = 1; k < WIN_LEN; k++) begin
            if (alive && cell_at(b, r0 + k*dr, c0 + k*dc)) n = n + 1;
            else alive = 1'b0;
        end
        return n;
    endfunction

    always_comb begin
        int total;
        total = 0;
        if (cell_at(board, int'(row), int'(col)))
            total = 1 + side_run(board, int'(row), int'(col),  int'(drow),  int'(dcol))
                      + side_run(board, int'(row), int'(col), -int'(drow), -int'(dcol));
        run = (total >= WIN_LEN) ? RUNW'(WIN_LEN) : RUNW'(total);
    end

endmodule

// File: rtl/win_scanner.sv
// Scans the four lines through a newly placed token for a WIN_LEN run, one
// direction per cycle. Define WIN_SCANNER_DRAW_DETECT_EN to enable draw reporting.
module win_scanner
    import win_pkg::*;
#(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int WIN_LEN = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ROWS-1:0][COLS-1:0] red,
    input  logic [ROWS-1:0][COLS-1:0] grn,
    input  logic [4:0]                newrow,
    input  logic [4:0]                newcolumn,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                result,
    output logic [1:0]                win_dir,
    output logic                      coord_err,
    output logic [6:0]                winner
);

    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);
    localparam int RUNW = $clog2(WIN_LEN+1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e                    state;
    dir_e                      dir_q;
    dir_e                      found_dir;
    result_e                   found_res;
    result_e                   final_res;
    logic [ROWS-1:0][COLS-1:0] red_l;
    logic [ROWS-1:0][COLS-1:0] grn_l;
    logic [4:0]                row_l;
    logic [4:0]                col_l;
    logic                      grn_here;
    logic [RUNW-1:0]           run;

    // Green takes priority when both boards claim the placed cell.
    always_comb begin
        grn_here = 1'b0;
        if (int'(row_l) < ROWS && int'(col_l) < COLS)
            grn_here = grn_l[RW'(row_l)][CW'(col_l)];
    end

    win_run_count #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN)
    ) u_run (
        .board (grn_here ? grn_l : red_l),
        .row   (row_l),
        .col   (col_l),
        .drow  (ROW_STEP[dir_q]),
        .dcol  (COL_STEP[dir_q]),
        .run   (run)
    );

    always_comb begin
        final_res = found_res;
`ifdef WIN_SCANNER_DRAW_DETECT_EN
        if (found_res == RES_NONE && !coord_err && (&(red_l[ROWS-1] | grn_l[ROWS-1])))
            final_res = RES_DRAW;
`endif
    end

    // Results are published on the DONE->IDLE edge together with the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dir_q     <= DIR_HORZ;
            found_dir <= DIR_HORZ;
            found_res <= RES_NONE;
            red_l     <= '0;
            grn_l     <= '0;
            row_l     <= '0;
            col_l     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= RES_NONE;
            win_dir   <= DIR_HORZ;
            coord_err <= 1'b0;
            winner    <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !done) begin
                        red_l     <= red;
                        grn_l     <= grn;
                        row_l     <= newrow;
                        col_l     <= newcolumn;
                        dir_q     <= DIR_HORZ;
                        found_dir <= DIR_HORZ;
                        found_res <= RES_NONE;
                        result    <= RES_NONE;
                        win_dir   <= DIR_HORZ;
                        winner    <= SEG_BLANK;
                        busy      <= 1'b1;
                        if (int'(newrow) >= ROWS || int'(newcolumn) >= COLS) begin
                            coord_err <= 1'b1;
                            state     <= DONE;
                        end else begin
                            coord_err <= 1'b0;
                            state     <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (int'(run) >= WIN_LEN) begin
                        found_res <= grn_here ? RES_GRN : RES_RED;
                        found_dir <= dir_q;
                        state     <= DONE;
                    end else if (dir_q == DIR_ANTI) begin
                        state <= DONE;
                    end else begin
                        dir_q <= dir_e'(dir_q + 2'd1);
                    end
                end
                DONE: begin
                    result  <= final_res;
                    win_dir <= found_dir;
                    winner  <= seg_of(final_res);
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_win_scanner.sv
// Directed, table-driven bench for win_scanner; draw expectations follow
// WIN_SCANNER_DRAW_DETECT_EN.
module tb_win_scanner;

    localparam int ROWS    = 16;
    localparam int COLS    = 16;
    localparam int WIN_LEN = 4;

    localparam logic [6:0] EXP_GRN   = 7'b1111001;
    localparam logic [6:0] EXP_RED   = 7'b0100100;
    localparam logic [6:0] EXP_DRAW  = 7'b0100001;
    localparam logic [6:0] EXP_BLANK = 7'b1111111;

`ifdef WIN_SCANNER_DRAW_DETECT_EN
    localparam logic [1:0] DRAW_RES = 2'd3;
`else
    localparam logic [1:0] DRAW_RES = 2'd0;
`endif

    logic                      clk;
    logic                      reset_n;
    logic [ROWS-1:0][COLS-1:0] red;
    logic [ROWS-1:0][COLS-1:0] grn;
    logic [4:0]                newrow;
    logic [4:0]                newcolumn;
    logic                      start;
    logic                      busy;
    logic                      done;
    logic [1:0]                result;
    logic [1:0]                win_dir;
    logic                      coord_err;
    logic [6:0]                winner;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string                     name;
        logic [ROWS-1:0][COLS-1:0] red;
        logic [ROWS-1:0][COLS-1:0] grn;
        logic [4:0]                row;
        logic [4:0]                col;
        logic [1:0]                res;
        logic [1:0]                dir;
        int                        lat;
        logic                      cerr;
    } vec_t;

    vec_t vecs[13];

    win_scanner #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .red       (red),
        .grn       (grn),
        .newrow    (newrow),
        .newcolumn (newcolumn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .win_dir   (win_dir),
        .coord_err (coord_err),
        .winner    (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [1:0] res);
        case (res)
            2'd1:    return EXP_GRN;
            2'd2:    return EXP_RED;
            2'd3:    return EXP_DRAW;
            default: return EXP_BLANK;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input string name, input logic [4:0] row, input logic [4:0] col,
                           input logic [1:0] res, input logic [1:0] dir, input int lat, input logic cerr);
        vecs[i].name = name;
        vecs[i].row  = row;
        vecs[i].col  = col;
        vecs[i].res  = res;
        vecs[i].dir  = dir;
        vecs[i].lat  = lat;
        vecs[i].cerr = cerr;
    endtask

    // Starts a scan, scrambles the live inputs to prove they were latched, and
    // waits (bounded) for done; lat is 0 on timeout.
    task automatic apply_stimulus(input vec_t v, output int lat);
        red       = v.red;
        grn       = v.grn;
        newrow    = v.row;
        newcolumn = v.col;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        red       = '0;
        grn       = '1;
        newrow    = 5'd7;
        newcolumn = 5'd7;
        check_output({v.name, " busy after start"}, busy, 1'b1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_done(input vec_t v, input int lat);
        check_output({v.name, " latency"}, lat, v.lat);
        check_output({v.name, " result"}, result, v.res);
        check_output({v.name, " win_dir"}, win_dir, v.dir);
        check_output({v.name, " coord_err"}, coord_err, v.cerr);
        check_output({v.name, " winner"}, winner, exp_seg(v.res));
        check_output({v.name, " busy at done"}, busy, 1'b0);
        @(posedge clk);
        #1;
        check_output({v.name, " done one cycle"}, done, 1'b0);
        check_output({v.name, " result held"}, result, v.res);
    endtask

    initial begin
        int lat;
        int saw_done;

        for (int i = 0; i < 13; i++) begin
            vecs[i].red = '0;
            vecs[i].grn = '0;
        end
        set_vec(0, "horz_grn", 5'd0, 5'd3, 2'd1, 2'd0, 2, 1'b0);
        for (int c = 0; c < 4; c++) vecs[0].grn[0][c] = 1'b1;
        set_vec(1, "vert_red", 5'd3, 5'd5, 2'd2, 2'd1, 3, 1'b0);
        for (int r = 3; r < 7; r++) vecs[1].red[r][5] = 1'b1;
        set_vec(2, "no_wrap", 5'd0, 5'd13, 2'd0, 2'd0, 5, 1'b0);
        vecs[2].grn[0][15] = 1'b1;
        vecs[2].grn[0][14] = 1'b1;
        vecs[2].grn[0][13] = 1'b1;
        vecs[2].grn[1][0]  = 1'b1;
        set_vec(3, "row_oob", 5'd20, 5'd2, 2'd0, 2'd0, 1, 1'b1);
        vecs[3].grn[0] = '1;
        set_vec(4, "diag_grn", 5'd4, 5'd4, 2'd1, 2'd2, 4, 1'b0);
        for (int k = 2; k < 6; k++) vecs[4].grn[k][k] = 1'b1;
        set_vec(5, "anti_red", 5'd5, 5'd2, 2'd2, 2'd3, 5, 1'b0);
        vecs[5].red[5][2] = 1'b1;
        vecs[5].red[6][1] = 1'b1;
        vecs[5].red[7][0] = 1'b1;
        vecs[5].red[4][3] = 1'b1;
        set_vec(6, "grn_priority", 5'd8, 5'd8, 2'd0, 2'd0, 5, 1'b0);
        for (int c = 8; c < 11; c++) vecs[6].grn[8][c] = 1'b1;
        for (int c = 8; c < 12; c++) vecs[6].red[8][c] = 1'b1;
        set_vec(7, "empty_cell", 5'd0, 5'd0, 2'd0, 2'd0, 5, 1'b0);
        for (int c = 1; c < 4; c++) vecs[7].red[0][c] = 1'b1;
        set_vec(8, "top_full", 5'd15, 5'd0, DRAW_RES, 2'd0, 5, 1'b0);
        for (int c = 0; c < COLS; c++) begin
            if (c % 2 == 0) vecs[8].grn[15][c] = 1'b1;
            else            vecs[8].red[15][c] = 1'b1;
        end
        set_vec(9, "both_sides", 5'd10, 5'd7, 2'd1, 2'd0, 2, 1'b0);
        vecs[9].grn[10][5] = 1'b1;
        vecs[9].grn[10][6] = 1'b1;
        vecs[9].grn[10][7] = 1'b1;
        vecs[9].grn[10][8] = 1'b1;
        set_vec(10, "edge_run3", 5'd1, 5'd15, 2'd0, 2'd0, 5, 1'b0);
        for (int r = 0; r < 3; r++) vecs[10].red[r][15] = 1'b1;
        set_vec(11, "col_oob", 5'd0, 5'd16, 2'd0, 2'd0, 1, 1'b1);
        set_vec(12, "corner_win", 5'd15, 5'd15, 2'd1, 2'd0, 2, 1'b0);
        for (int c = 12; c < 16; c++) vecs[12].grn[15][c] = 1'b1;

        reset_n   = 1'b0;
        start     = 1'b0;
        red       = '0;
        grn       = '0;
        newrow    = '0;
        newcolumn = '0;
        #12;
        check_output("reset busy", busy, 1'b0);
        check_output("reset done", done, 1'b0);
        check_output("reset result", result, 2'd0);
        check_output("reset winner", winner, EXP_BLANK);
        #11;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i], lat);
            check_done(vecs[i], lat);
        end

        // A start raised while done is high must be ignored; results stay held.
        apply_stimulus(vecs[0], lat);
        check_output("hold latency", lat, 2);
        red       = vecs[1].red;
        grn       = vecs[1].grn;
        newrow    = vecs[1].row;
        newcolumn = vecs[1].col;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("ignored start busy", busy, 1'b0);
        check_output("ignored start done", done, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_output("hold busy", busy, 1'b0);
        check_output("hold result", result, 2'd1);
        check_output("hold winner", winner, EXP_GRN);

        // Reset in the second SCAN cycle of a diagonal scan aborts it silently.
        red       = vecs[4].red;
        grn       = vecs[4].grn;
        newrow    = vecs[4].row;
        newcolumn = vecs[4].col;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_output("mid busy before reset", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check_output("abort busy", busy, 1'b0);
        check_output("abort done", done, 1'b0);
        check_output("abort result", result, 2'd0);
        check_output("abort win_dir", win_dir, 2'd0);
        check_output("abort coord_err", coord_err, 1'b0);
        check_output("abort winner", winner, EXP_BLANK);
        #2;
        reset_n  = 1'b1;
        saw_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done++;
        end
        check_output("no done after abort", saw_done, 0);
        apply_stimulus(vecs[4], lat);
        check_done(vecs[4], lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/win_scanner.md
WIN_SCANNER -- requirements
Module: win_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 16, meaning board row count (4..32).
REQ-002 SHALL have parameter COLS, default 16, meaning board column count (4..32).
REQ-003 SHALL have parameter WIN_LEN, default 4, meaning the run length that wins (2..min(ROWS,COLS)).
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports red and grn, input, [ROWS-1:0][COLS-1:0], occupancy boards.
REQ-007 SHALL have ports newrow and newcolumn, input, 5 each, coordinates of the token just placed.
REQ-008 SHALL have port start, input, 1, scan request.
REQ-009 SHALL have port busy, output, 1, high while a scan is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port result, output, 2, coded as 0 none, 1 green, 2 red, 3 draw.
REQ-012 SHALL have port win_dir, output, 2, coded as 0 horizontal, 1 vertical, 2 diagonal (+row,+col), 3 anti-diagonal (+row,-col).
REQ-013 SHALL have port coord_err, output, 1, flagging a placed coordinate outside the board.
REQ-014 SHALL have port winner, output, 7, active-low 7-segment code: 1111001 green, 0100100 red, 0100001 draw, 1111111 otherwise.

Function
REQ-015 SHALL use FSM states IDLE, SCAN and DONE.
REQ-016 SHALL, in IDLE with start=1, latch red, grn, newrow and newcolumn, clear coord_err, and go to SCAN with direction counter 0.
REQ-017 SHALL ignore start while busy; the latched board stays stable for the whole scan.
REQ-018 SHALL evaluate one direction per SCAN cycle: count contiguous same-colour cells through the placed cell, both ways, up to WIN_LEN-1 steps each side.
REQ-019 SHALL stop counting at the board edge; indices never wrap or alias.
REQ-020 SHALL take the colour under test from the latched placed cell; green wins if both red and grn are set there.
REQ-021 SHALL, if the count reaches WIN_LEN or more, record the colour and direction and go to DONE.
REQ-022 SHALL otherwise increment the direction, and go to DONE after direction 3.
REQ-023 SHALL make the latency: with N directions evaluated (1..4), done is high for exactly one cycle, N+1 clocks after the start edge; busy is high from the edge after start until done.
REQ-024 SHALL, when the placed cell is empty in both boards, scan all 4 directions and report result 0.
REQ-025 SHALL, when newrow>=ROWS or newcolumn>=COLS, go IDLE->DONE directly (latency 1) with coord_err=1 and result 0.
REQ-026 SHALL hold result, win_dir, winner and coord_err from done until the next accepted start; win_dir=0 when no win.
REQ-027 SHALL allow a start in the cycle done is high to be ignored; start is accepted again in IDLE.

Reset
REQ-028 SHALL, on reset_n low (asserted asynchronously, including mid-scan), set state IDLE, busy=0, done=0, result=0, win_dir=0, coord_err=0, winner=1111111, and clear all latches.
REQ-029 SHALL never emit a done pulse for a scan aborted by reset.

Configuration
REQ-030 SHALL, with macro WIN_SCANNER_DRAW_DETECT_EN defined, report result 3 and winner 0100001 when no win is found and every cell of latched row ROWS-1 (top) is occupied in red|grn.
REQ-031 SHALL, without WIN_SCANNER_DRAW_DETECT_EN, contain no draw logic and never produce result 3.

Structure
REQ-032 SHALL put in package win_pkg: the result_e and dir_e enums, the 7-segment constants SEG_GRN, SEG_RED, SEG_DRAW and SEG_BLANK, and a per-direction row/column step table.
REQ-033 SHALL instantiate one sub-module, win_run_count: combinational, parametrised by ROWS, COLS and WIN_LEN; it takes a board, coordinate and step, and returns the saturated run length.

Verification
REQ-034 SHALL cover: grn cells (0,0..3) set, place (0,3), start -> done 2 cycles after start, result 1, win_dir 0, winner 1111001.
REQ-035 SHALL cover: red cells (3..6,5) set, place (3,5) -> done 3 cycles after start, result 2, win_dir 1, winner 0100100.
REQ-036 SHALL cover: grn cells (0,15),(0,14),(0,13) plus (1,0) set, place (0,13) -> result 0 after 5 cycles (no wrap at the edge).
REQ-037 SHALL cover: place (20,2) with ROWS=16 -> done 1 cycle after start, coord_err 1, result 0.
REQ-038 SHALL cover: start a diagonal scan, pulse reset_n low in the 2nd SCAN cycle -> all outputs at reset values immediately, no done pulse; a new start then completes normally.
REQ-039 SHALL cover, under WIN_SCANNER_DRAW_DETECT_EN: top row fully occupied, no run, start -> result 3, winner 0100001; without the macro -> result 0.
